// File: rtl/eager_fork_n.sv
`default_nettype none
// ============================================================================
// Module      : eager_fork_n
// Description : Eager ready/valid fork broadcasting one input stream to N
//               channels under a per-beat channel-enable mask.
// Revision    : 1.0
// ============================================================================
module eager_fork_n #(
    parameter int WIDTH = 32,
    parameter int N     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [N-1:0]       in_mask,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               busy,
    output logic [7:0]         drop_count
);

    localparam logic [7:0] C_DROP_MAX = 8'hFF;

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [7:0]       drop_q, drop_d;

    logic [N-1:0]     fire;
    logic [N-1:0]     pend_nx;
    logic             last;
    logic             acc;

    always_comb begin
        out_valid = {N{full_q}} & pend_q;
        fire      = out_valid & out_ready;
        pend_nx   = pend_q & ~fire;
        last      = full_q && (pend_nx == '0);
        in_ready  = reset && (!full_q || last);
        acc       = in_valid && in_ready;

        full_d = full_q;
        data_d = data_q;
        pend_d = pend_nx;
        drop_d = drop_q;

        if (acc) begin
            if (in_mask != '0) begin
                full_d = 1'b1;
                data_d = in_data;
                pend_d = in_mask;
            end else begin
                // A zero-mask beat is consumed with no delivery.
                full_d = 1'b0;
                pend_d = '0;
                drop_d = (drop_q == C_DROP_MAX) ? drop_q : drop_q + 8'd1;
            end
        end else if (last) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            full_q <= 1'b0;
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            assign out_data[gi*WIDTH +: WIDTH] = data_q;
        end
    endgenerate

    assign busy       = full_q;
    assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_eager_fork_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_eager_fork_n
// Description : Directed and scoreboarded checks for eager_fork_n (N=4, 16b).
// Revision    : 1.0
// ============================================================================
module tb_eager_fork_n;

    localparam int W  = 16;
    localparam int NC = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [NC-1:0]   in_mask;
    logic [NC-1:0]   out_valid;
    logic [NC-1:0]   out_ready;
    logic [NC*W-1:0] out_data;
    logic            busy;
    logic [7:0]      drop_count;

    int n_total = 0;
    int n_pass  = 0;

    eager_fork_n #(.WIDTH(W), .N(NC)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] bcast(input logic [W-1:0] v);
        return {v, v, v, v};
    endfunction

    logic [W-1:0]  exp_data [NC];
    logic [NC-1:0] exp_pend;
    logic [NC-1:0] prev_stall;
    logic [W-1:0]  prev_data;
    logic [NC-1:0] fire_s;
    int            drops;

    initial begin
        reset = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        in_mask = 4'hF; out_ready = 4'hF;

        // Reset held: nothing accepted, nothing presented
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_drop", drop_count, 0);
        end
        reset = 1'b1; in_valid = 1'b0; #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);

        // Broadcast at full rate
        in_valid = 1'b1; in_mask = 4'hF; out_ready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            in_data = W'(i); #1;
            check("bc_in_ready", in_ready, 1);
            if (i > 0) begin
                check("bc_valid", out_valid, 4'hF);
                check("bc_data", out_data, bcast(W'(i - 1)));
            end
        end
        tick(); in_valid = 1'b0; #1;
        check("bc_valid_last", out_valid, 4'hF);
        check("bc_data_last", out_data, bcast(16'h7));
        tick(); #1;
        check("bc_empty", out_valid, 0);

        // Eager independent stall on ch1
        in_valid = 1'b1; in_data = 16'h00A5; in_mask = 4'b0011; out_ready = 4'b0001;
        tick(); in_data = 16'h005A; #1;
        check("st_valid1", out_valid, 4'b0011);
        check("st_data1", out_data[W +: W], 16'h00A5);
        check("st_in_ready1", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("st_valid_hold", out_valid, 4'b0010);
            check("st_data_hold", out_data[W +: W], 16'h00A5);
            check("st_in_ready_hold", in_ready, 0);
        end
        tick(); out_ready = 4'b0011; #1;
        check("st_valid_fire", out_valid, 4'b0010);
        check("st_in_ready_fire", in_ready, 1);
        tick(); in_valid = 1'b0; out_ready = 4'hF; #1;
        check("st_next_valid", out_valid, 4'b0011);
        check("st_next_data", out_data[W +: W], 16'h005A);
        tick(); #1;
        check("st_empty", out_valid, 0);

        // Masked delivery, then zero-mask drops up to saturation
        in_valid = 1'b1; in_data = 16'h0077; in_mask = 4'b0010; out_ready = 4'h0;
        tick(); in_valid = 1'b0; #1;
        check("mk_valid", out_valid, 4'b0010);
        check("mk_data", out_data[W +: W], 16'h0077);
        out_ready = 4'hF;
        tick();
        in_valid = 1'b1; in_mask = 4'h0;
        for (int i = 0; i < 300; i++) begin
            #1;
            check("dr_valid", out_valid, 0);
            check("dr_in_ready", in_ready, 1);
            check("dr_count", drop_count, (i > 255) ? 255 : i);
            tick();
        end
        in_valid = 1'b0; #1;
        check("dr_sat", drop_count, 8'd255);

        // Mid-transfer reset discards the held beat
        in_valid = 1'b1; in_data = 16'h0033; in_mask = 4'b0011; out_ready = 4'b0001;
        tick(); in_valid = 1'b0; #1;
        check("mr_valid", out_valid, 4'b0011);
        tick(); reset = 1'b0; #1;
        check("mr_valid_stall", out_valid, 4'b0010);
        check("mr_in_ready_rst", in_ready, 0);
        tick(); reset = 1'b1; out_ready = 4'hF; #1;
        check("mr_valid_after", out_valid, 0);
        check("mr_busy_after", busy, 0);
        check("mr_drop_after", drop_count, 0);
        tick(); #1;
        check("mr_no_redeliver", out_valid, 0);
        in_valid = 1'b1; in_data = 16'h0044; in_mask = 4'b0011;
        tick(); in_valid = 1'b0; #1;
        check("mr_next_valid", out_valid, 4'b0011);
        check("mr_next_data", out_data[W +: W], 16'h0044);
        tick(); #1;
        check("mr_next_empty", out_valid, 0);

        // Random soak with per-channel scoreboard
        exp_pend = '0; prev_stall = '0; prev_data = '0; drops = 0;
        for (int c = 0; c < NC; c++) exp_data[c] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            in_mask   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            out_ready = 4'($urandom);
            #1;
            for (int c = 0; c < NC; c++) begin
                if (prev_stall[c]) begin
                    check("sk_stall_valid", out_valid[c], 1);
                    check("sk_stall_data", out_data[c*W +: W], prev_data);
                end
                if (out_valid[c]) check("sk_valid_pending", exp_pend[c], 1);
            end
            fire_s = out_valid & out_ready;
            for (int c = 0; c < NC; c++) begin
                if (fire_s[c]) begin
                    check("sk_fire_data", out_data[c*W +: W], exp_data[c]);
                    exp_pend[c] = 1'b0;
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data[W-1:0];
            if (in_valid && in_ready) begin
                if (in_mask == 4'h0) drops++;
                for (int c = 0; c < NC; c++) begin
                    if (in_mask[c]) begin
                        check("sk_no_loss", exp_pend[c], 0);
                        exp_pend[c] = 1'b1;
                        exp_data[c] = in_data;
                    end
                end
            end
        end
        tick(); in_valid = 1'b0; out_ready = 4'hF; #1;
        fire_s = out_valid & out_ready;
        for (int c = 0; c < NC; c++) begin
            if (fire_s[c]) begin
                check("sk_drain_data", out_data[c*W +: W], exp_data[c]);
                exp_pend[c] = 1'b0;
            end
        end
        tick(); #1;
        check("sk_all_delivered", exp_pend, 0);
        check("sk_empty", out_valid, 0);
        check("sk_drops", drop_count, (drops > 255) ? 255 : drops);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
